// File: rtl/mem_check_pkg.sv
// Shared types for the store-monitor checker: FSM states and failure codes.
package mem_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  // FC_ prefix keeps these clear of the TIMEOUT parameter in importing modules.
  typedef enum logic [1:0] {
    FC_NONE          = 2'd0,
    FC_DATA_MISMATCH = 2'd1,
    FC_TIMEOUT       = 2'd2,
    FC_NO_EXPECT     = 2'd3
  } fail_code_t;

endpackage

// File: rtl/expect_table.sv
// Expected-write table: entry storage, valid/hit bits and the combinational
// lowest-index candidate search used by the checker FSM.
module expect_table #(
  parameter int unsigned N       = 32,
  parameter int unsigned A       = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ORDERED = 1,
  parameter int unsigned IW      = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [IW-1:0] load_idx_i,
  input  logic [A-1:0]  load_addr_i,
  input  logic [N-1:0]  load_data_i,
  input  logic          clr_hits_i,
  input  logic          set_hit_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [A-1:0]  st_addr_i,
  input  logic [N-1:0]  st_data_i,
  output logic          any_valid_c,
  output logic [IW-1:0] first_valid_c,
  output logic          cand_found_c,
  output logic          cand_data_ok_c,
  output logic          complete_c,
  output logic [IW-1:0] next_ptr_c
);

  logic [A-1:0]     addr_q [DEPTH];
  logic [N-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] hit_q;
  logic [DEPTH-1:0] hit_after;
  logic [IW-1:0]    cand_idx;
  logic             load_ok;

  assign load_ok = load_i && (32'(load_idx_i) < 32'(DEPTH));

  // Entry payload carries no reset; it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      addr_q[load_idx_i] <= load_addr_i;
      data_q[load_idx_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      hit_q   <= '0;
    end else begin
      if (load_ok) begin
        valid_q[load_idx_i] <= 1'b1;
      end
      if (clr_hits_i) begin
        hit_q <= '0;
      end else if (set_hit_i) begin
        hit_q[cand_idx] <= 1'b1;
      end
    end
  end

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    cand_found_c  = 1'b0;
    cand_idx      = '0;
    any_valid_c   = |valid_q;
    first_valid_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i]) begin
        first_valid_c = IW'(i);
      end
      if (valid_q[i] && !hit_q[i] && (addr_q[i] == st_addr_i) &&
          ((ORDERED == 0) || (ptr_i == IW'(i)))) begin
        cand_found_c = 1'b1;
        cand_idx     = IW'(i);
      end
    end

    next_ptr_c = cand_idx;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (IW'(i) > cand_idx)) begin
        next_ptr_c = IW'(i);
      end
    end

    hit_after           = hit_q;
    hit_after[cand_idx] = 1'b1;
    complete_c          = cand_found_c && (hit_after == valid_q);
    cand_data_ok_c      = (data_q[cand_idx] == st_data_i);
  end

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking store monitor: watches memwrite/dataadr/writedata against a
// table of expected writes and reports pass/fail, matches and elapsed cycles.
module mem_write_checker
  import mem_check_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned A       = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ORDERED = 1,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1),
  localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned MW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic          exp_load,
  input  logic [IW-1:0] exp_idx,
  input  logic [A-1:0]  exp_addr,
  input  logic [N-1:0]  exp_data,
  input  logic          memwrite,
  input  logic [A-1:0]  dataadr,
  input  logic [N-1:0]  writedata,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic [MW-1:0] match_count,
  output logic [CW-1:0] cycle_count
);

  state_t        state_q, state_d;
  fail_code_t    code_q, code_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic [MW-1:0] match_q, match_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          load_en_c;
  logic          clr_hits_c;
  logic          set_hit_c;
  logic          any_valid_c;
  logic [IW-1:0] first_valid_c;
  logic          cand_found_c;
  logic          cand_data_ok_c;
  logic          complete_c;
  logic [IW-1:0] next_ptr_c;

  assign load_en_c = exp_load && (state_q == IDLE);

  expect_table #(
    .N       (N),
    .A       (A),
    .DEPTH   (DEPTH),
    .ORDERED (ORDERED),
    .IW      (IW)
  ) u_table (
    .clk            (clk),
    .reset          (reset),
    .load_i         (load_en_c),
    .load_idx_i     (exp_idx),
    .load_addr_i    (exp_addr),
    .load_data_i    (exp_data),
    .clr_hits_i     (clr_hits_c),
    .set_hit_i      (set_hit_c),
    .ptr_i          (ptr_q),
    .st_addr_i      (dataadr),
    .st_data_i      (writedata),
    .any_valid_c    (any_valid_c),
    .first_valid_c  (first_valid_c),
    .cand_found_c   (cand_found_c),
    .cand_data_ok_c (cand_data_ok_c),
    .complete_c     (complete_c),
    .next_ptr_c     (next_ptr_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= FC_NONE;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      match_q <= '0;
      cyc_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      match_q <= match_d;
      cyc_q   <= cyc_d;
      ptr_q   <= ptr_d;
    end
  end

  // Priority within an enabled RUN cycle: data mismatch, then completion, then timeout.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    match_d    = match_q;
    cyc_d      = cyc_q;
    ptr_d      = ptr_q;
    clr_hits_c = 1'b0;
    set_hit_c  = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      code_d     = FC_NONE;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      match_d    = '0;
      cyc_d      = '0;
      clr_hits_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            if (any_valid_c) begin
              state_d    = RUN;
              cyc_d      = '0;
              match_d    = '0;
              ptr_d      = first_valid_c;
              clr_hits_c = 1'b1;
            end else begin
              state_d = FAIL;
              code_d  = FC_NO_EXPECT;
              fail_d  = 1'b1;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (cyc_q != CW'(TIMEOUT)) begin
              cyc_d = cyc_q + CW'(1);
            end
            if (memwrite && cand_found_c && !cand_data_ok_c) begin
              state_d = FAIL;
              code_d  = FC_DATA_MISMATCH;
              fail_d  = 1'b1;
              done_d  = 1'b1;
            end else if (memwrite && cand_found_c) begin
              set_hit_c = 1'b1;
              match_d   = match_q + MW'(1);
              ptr_d     = next_ptr_c;
              if (complete_c) begin
                state_d = PASS;
                pass_d  = 1'b1;
                done_d  = 1'b1;
              end else if (cyc_q == CW'(TIMEOUT - 1)) begin
                state_d = FAIL;
                code_d  = FC_TIMEOUT;
                fail_d  = 1'b1;
                done_d  = 1'b1;
              end
            end else if (cyc_q == CW'(TIMEOUT - 1)) begin
              state_d = FAIL;
              code_d  = FC_TIMEOUT;
              fail_d  = 1'b1;
              done_d  = 1'b1;
            end
          end
        end
        PASS, FAIL: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = code_q;
  assign match_count = match_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: an ordered and an unordered instance share one
// directed stimulus stream and are checked against a behavioural model.
module tb_mem_write_checker;

  localparam int unsigned TO = 10;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        enable;
  logic        exp_load;
  logic [1:0]  exp_idx;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  logic        dn [2];
  logic        ps [2];
  logic        fl [2];
  logic [1:0]  fc [2];
  logic [2:0]  mc [2];
  logic [3:0]  cc [2];

  int total = 0;
  int bad   = 0;

  // Instance 0 is ordered, instance 1 unordered.
  mem_write_checker #(.N(32), .A(32), .DEPTH(4), .ORDERED(1), .TIMEOUT(TO)) u_ord (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .exp_load(exp_load), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(dn[0]), .pass(ps[0]), .fail(fl[0]), .fail_code(fc[0]),
    .match_count(mc[0]), .cycle_count(cc[0])
  );

  mem_write_checker #(.N(32), .A(32), .DEPTH(4), .ORDERED(0), .TIMEOUT(TO)) u_uno (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .exp_load(exp_load), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(dn[1]), .pass(ps[1]), .fail(fl[1]), .fail_code(fc[1]),
    .match_count(mc[1]), .cycle_count(cc[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: phase 0 idle, 1 run, 2 pass, 3 fail.
  int          m_phase [2];
  int          m_code  [2];
  int          m_match [2];
  int          m_cyc   [2];
  bit          m_valid [2][4];
  bit          m_hit   [2][4];
  logic [31:0] m_addr  [2][4];
  logic [31:0] m_data  [2][4];

  task automatic model_step(input int m);
    bit any_v;
    bit mism;
    bit all_hit;
    int old_phase;
    int old_cyc;
    int head;
    int c;
    any_v     = 1'b0;
    mism      = 1'b0;
    old_phase = m_phase[m];
    for (int i = 0; i < 4; i++) any_v |= m_valid[m][i];
    if (old_phase == 0 && exp_load) begin
      m_valid[m][exp_idx] = 1'b1;
      m_addr[m][exp_idx]  = exp_addr;
      m_data[m][exp_idx]  = exp_data;
    end
    if (clear) begin
      m_phase[m] = 0; m_code[m] = 0; m_match[m] = 0; m_cyc[m] = 0;
      for (int i = 0; i < 4; i++) m_hit[m][i] = 1'b0;
    end else if (old_phase == 0 && enable) begin
      if (any_v) begin
        m_phase[m] = 1; m_cyc[m] = 0; m_match[m] = 0;
        for (int i = 0; i < 4; i++) m_hit[m][i] = 1'b0;
      end else begin
        m_phase[m] = 3; m_code[m] = 3;
      end
    end else if (old_phase == 1 && enable) begin
      old_cyc  = m_cyc[m];
      m_cyc[m] = (old_cyc + 1 > int'(TO)) ? int'(TO) : old_cyc + 1;
      c = -1;
      if (memwrite === 1'b1) begin
        if (m == 0) begin
          head = -1;
          for (int i = 3; i >= 0; i--) if (m_valid[m][i] && !m_hit[m][i]) head = i;
          if (head >= 0 && m_addr[m][head] == dataadr) c = head;
        end else begin
          for (int i = 3; i >= 0; i--)
            if (m_valid[m][i] && !m_hit[m][i] && m_addr[m][i] == dataadr) c = i;
        end
        if (c >= 0) begin
          if (m_data[m][c] == writedata) begin
            m_hit[m][c] = 1'b1;
            m_match[m]++;
          end else begin
            mism = 1'b1;
          end
        end
      end
      all_hit = 1'b1;
      for (int i = 0; i < 4; i++) if (m_valid[m][i] && !m_hit[m][i]) all_hit = 1'b0;
      if (mism) begin
        m_phase[m] = 3; m_code[m] = 1;
      end else if (all_hit) begin
        m_phase[m] = 2;
      end else if (old_cyc == int'(TO) - 1) begin
        m_phase[m] = 3; m_code[m] = 2;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_phase[m] = 0; m_code[m] = 0; m_match[m] = 0; m_cyc[m] = 0;
        for (int i = 0; i < 4; i++) begin
          m_valid[m][i] = 1'b0;
          m_hit[m][i]   = 1'b0;
        end
      end
    end else begin
      for (int m = 0; m < 2; m++) model_step(m);
    end
  end

  task automatic chk(input string nm, input int m, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got %0d want %0d", nm, m, $time, act, exp_v);
    end
  endtask

  // Every negedge out of reset: DUT outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        chk("model_done",  m, int'(dn[m]), int'(m_phase[m] >= 2));
        chk("model_pass",  m, int'(ps[m]), int'(m_phase[m] == 2));
        chk("model_fail",  m, int'(fl[m]), int'(m_phase[m] == 3));
        chk("model_code",  m, int'(fc[m]), m_code[m]);
        chk("model_match", m, int'(mc[m]), m_match[m]);
        chk("model_cycle", m, int'(cc[m]), m_cyc[m]);
      end
    end
  end

  task automatic lit(input int m, input int e_dn, input int e_ps, input int e_fl,
                     input int e_fc, input int e_mc, input int e_cc);
    chk("lit_done",  m, int'(dn[m]), e_dn);
    chk("lit_pass",  m, int'(ps[m]), e_ps);
    chk("lit_fail",  m, int'(fl[m]), e_fl);
    chk("lit_code",  m, int'(fc[m]), e_fc);
    chk("lit_match", m, int'(mc[m]), e_mc);
    chk("lit_cycle", m, int'(cc[m]), e_cc);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    exp_load = 1'b1; exp_idx = 2'(idx); exp_addr = a; exp_data = d;
    tick();
    exp_load = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; enable = 1'b0; exp_load = 1'b0;
    exp_idx = '0; exp_addr = '0; exp_data = '0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;
    repeat (2) tick();
    reset = 1'b0;
    lit(0, 0, 0, 0, 0, 0, 0);
    lit(1, 0, 0, 0, 0, 0, 0);

    // Single entry hit at RUN cycle 5.
    load(0, 32'd84, 32'h96);
    enable = 1'b1;
    tick();
    repeat (5) tick();
    store(32'd84, 32'h96);
    lit(0, 1, 1, 0, 0, 1, 6);
    lit(1, 1, 1, 0, 0, 1, 6);
    enable = 1'b0;
    do_clear();
    lit(0, 0, 0, 0, 0, 0, 0);

    // Two entries; a load during RUN must not disturb entry 1.
    load(0, 32'd80, 32'h7);
    load(1, 32'd84, 32'h96);
    enable = 1'b1;
    tick();
    load(1, 32'd84, 32'h55);
    store(32'd84, 32'h96);
    lit(0, 0, 0, 0, 0, 0, 2);
    lit(1, 0, 0, 0, 0, 1, 2);
    store(32'd80, 32'h7);
    lit(0, 0, 0, 0, 0, 1, 3);
    lit(1, 1, 1, 0, 0, 2, 3);
    store(32'd84, 32'h96);
    lit(0, 1, 1, 0, 0, 2, 4);
    lit(1, 1, 1, 0, 0, 2, 3);
    enable = 1'b0;
    do_clear();

    // Data mismatch on the unordered instance only.
    enable = 1'b1;
    tick();
    store(32'd84, 32'h95);
    lit(0, 0, 0, 0, 0, 0, 1);
    lit(1, 1, 0, 1, 1, 0, 1);
    store(32'd80, 32'h7);
    lit(0, 0, 0, 0, 0, 1, 2);

    // Asynchronous reset between edges, then enable with an empty table.
    #2 reset = 1'b1;
    #1;
    lit(0, 0, 0, 0, 0, 0, 0);
    lit(1, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    lit(0, 1, 0, 1, 3, 0, 0);
    lit(1, 1, 0, 1, 3, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    lit(0, 0, 0, 0, 0, 0, 0);
    tick();
    lit(1, 1, 0, 1, 3, 0, 0);
    enable = 1'b0;
    do_clear();
    lit(1, 0, 0, 0, 0, 0, 0);

    // Timeout after exactly TO enabled cycles, with an unchecked store inside.
    load(0, 32'd84, 32'h96);
    enable = 1'b1;
    tick();
    repeat (4) tick();
    store(32'd88, 32'h96);
    repeat (4) tick();
    lit(0, 0, 0, 0, 0, 0, 9);
    tick();
    lit(0, 1, 0, 1, 2, 0, 10);
    lit(1, 1, 0, 1, 2, 0, 10);
    enable = 1'b0;
    do_clear();

    // Pausing enable stretches the timeout by the paused cycles.
    enable = 1'b1;
    tick();
    repeat (4) tick();
    enable = 1'b0;
    repeat (3) tick();
    lit(0, 0, 0, 0, 0, 0, 4);
    enable = 1'b1;
    repeat (5) tick();
    lit(1, 0, 0, 0, 0, 0, 9);
    tick();
    lit(1, 1, 0, 1, 2, 0, 10);
    enable = 1'b0;
    do_clear();

    // A final match on the timeout cycle resolves to PASS.
    enable = 1'b1;
    tick();
    repeat (9) tick();
    store(32'd84, 32'h96);
    lit(0, 1, 1, 0, 0, 1, 10);
    lit(1, 1, 1, 0, 0, 1, 10);
    enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
